serial_frame_sink: RTL
======================

SERIAL_FRAME_SINK -- requirements
Module: serial_frame_sink

Interface
REQ-001 The module SHALL have parameter FRAME_BITS, default 21, total bits per serial frame.
REQ-002 The module SHALL have parameter N_FRAMES, default 8, number of frames written before completion.
REQ-003 The module SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port sen  input  1  serial enable; 1 = idle/frame gap, 0 = frame bit valid.
REQ-006 The module SHALL have port sd  input  1  serial data, MSB first.
REQ-007 The module SHALL have port mem_wen  output  1  memory write enable, active-low (1 = read/idle).
REQ-008 The module SHALL have port mem_a  output  3  memory word address.
REQ-009 The module SHALL have port mem_d  output  18  memory write data.
REQ-010 The module SHALL have port done  output  1  level; high once N_FRAMES frames are written.
REQ-011 The module SHALL have port frame_err  output  1  one-cycle pulse on a short (truncated) frame.
REQ-012 The module SHALL have port err_cnt  output  4  saturating count of short and overlong frames.

Function
REQ-013 Sampling SHALL occur only on posedge clk with sen==0; sd shifts into a 21-bit register, MSB first.
REQ-014 Frame layout SHALL be bits[20:18] = address and bits[17:0] = data.
REQ-015 FSM states SHALL be IDLE, SHIFT, HOLD, and DONE.
REQ-016 IDLE SHALL go to SHIFT on the first sampled bit (sen==0), with bit_cnt=1.
REQ-017 SHIFT SHALL increment bit_cnt per sampled bit and go to HOLD when the 21st bit is sampled.
REQ-018 In HOLD, sen==1 SHALL return the FSM to IDLE.
REQ-019 In HOLD, each further sen==0 bit (overlong frame) SHALL be ignored without shifting, and err_cnt SHALL increment once per overlong frame.
REQ-020 Write SHALL occur in the cycle after the 21st bit: mem_wen=0, mem_a=bits[20:18], mem_d=bits[17:0] for exactly one cycle, from a holding register independent of the shifter.
REQ-021 A write SHALL NOT block reception: a new frame starting the cycle after the write SHALL be sampled correctly; the minimum frame gap is one sen==1 cycle.
REQ-022 Short frame: sen==1 in SHIFT with bit_cnt<21 SHALL discard the frame (no write), pulse frame_err for one cycle, increment err_cnt, and return the FSM to IDLE.
REQ-023 A frame-written counter SHALL increment per write; after write number N_FRAMES, done SHALL rise the following cycle and the FSM SHALL enter DONE.
REQ-024 DONE SHALL be terminal until reset; sen/sd SHALL be ignored there; mem_wen SHALL stay 1.
REQ-025 err_cnt SHALL saturate at 15.
REQ-026 Duplicate addresses SHALL simply overwrite; no address checking SHALL be performed.
REQ-027 Outside a write cycle, mem_wen SHALL be 1; mem_a and mem_d SHALL hold their last values.

Reset
REQ-028 rst==0 SHALL asynchronously force: FSM=IDLE, bit_cnt=0, shifter=0, frame counter=0, mem_wen=1, mem_a=0, mem_d=0, done=0, frame_err=0, err_cnt=0.
REQ-029 Reset mid-frame or mid-write SHALL abort with no partial write; the first frame after release SHALL be received normally.

Structure
REQ-030 A shared package SHALL hold FRAME_BITS, ADDR_W=3, DATA_W=18, N_FRAMES, and the FSM state enum.
REQ-031 One sub-module, sfs_shift_rx (shifter plus bit counter with a frame_full flag), SHALL be used; the FSM, write register, and counters SHALL live in the top module.

Verification
REQ-032 Eight frames, addr 0..7, data 18'h3FFFF, 18'h00000, 18'h2AAAA, ..., with one-cycle gaps -> memory words 0..7 match, and done rises one cycle after the 8th write.
REQ-033 Frame {3'b101, 18'h1A5C3} -> exactly one cycle with mem_wen=0, mem_a=5, mem_d=18'h1A5C3, one cycle after the 21st bit.
REQ-034 Frame truncated after 10 bits (sen=1) -> frame_err pulses once, err_cnt=1, no write, and the next full frame is written correctly.
REQ-035 Frame of 24 low-sen bits -> one write using the first 21 bits, err_cnt=1, and the following frame is received correctly.
REQ-036 rst=0 asserted at bit 12 of frame 3, then released -> all outputs at reset values, and a fresh 8-frame sequence produces done with no stale write.
REQ-037 Twenty short frames -> err_cnt saturates at 15 and done remains 0.

Source files
------------

// File: rtl/serial_frame_sink_pkg.sv
// Shared constants, FSM state type and helpers for the serial frame sink.
package serial_frame_sink_pkg;

    localparam int unsigned FRAME_BITS = 21;
    localparam int unsigned ADDR_W     = 3;
    localparam int unsigned DATA_W     = 18;
    localparam int unsigned N_FRAMES   = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD,
        DONE
    } state_t;

    // Increment a 4-bit error count, sticking at all-ones.
    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/serial_frame_sink_shift_rx.sv
// Serial receive shifter with bit counter; MSB arrives first.
module sfs_shift_rx #(
    parameter int unsigned FRAME_BITS = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sd,
    input  logic                  shift_en,
    input  logic                  first,
    output logic [FRAME_BITS-1:0] word,
    output logic                  frame_full
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;

    // Word as it stands including the bit on sd, so a completed frame can be
    // captured on the same edge that samples its last bit.
    assign word       = {shift_q[FRAME_BITS-2:0], sd};
    // High when the next sampled bit completes the frame.
    assign frame_full = (bit_cnt == CNT_W'(FRAME_BITS - 1));

    // Shift register and bit counter; the first bit of a frame restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (shift_en) begin
            shift_q <= word;
            bit_cnt <= first ? CNT_W'(1) : bit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_sink.sv
// Serial frame sink: receives address/data frames and writes them to a memory port.
module serial_frame_sink #(
    parameter int unsigned FRAME_BITS = serial_frame_sink_pkg::FRAME_BITS,
    parameter int unsigned N_FRAMES   = serial_frame_sink_pkg::N_FRAMES
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    sen,
    input  logic                                    sd,
    output logic                                    mem_wen,
    output logic [serial_frame_sink_pkg::ADDR_W-1:0] mem_a,
    output logic [serial_frame_sink_pkg::DATA_W-1:0] mem_d,
    output logic                                    done,
    output logic                                    frame_err,
    output logic [3:0]                              err_cnt
);

    import serial_frame_sink_pkg::*;

    localparam int unsigned CNT_W = $clog2(N_FRAMES + 1);

    state_t                state;
    state_t                next_state;
    logic                  shift_en;
    logic                  first;
    logic                  launch;
    logic                  short_err;
    logic                  over_err;
    logic                  over_seen;
    logic                  write_end;
    logic                  last_write;
    logic [CNT_W-1:0]      frame_cnt;
    logic [FRAME_BITS-1:0] word;
    logic                  frame_full;

    sfs_shift_rx #(
        .FRAME_BITS(FRAME_BITS)
    ) u_shift_rx (
        .clk       (clk),
        .rst       (rst),
        .sd        (sd),
        .shift_en  (shift_en),
        .first     (first),
        .word      (word),
        .frame_full(frame_full)
    );

    assign write_end  = ~mem_wen;
    assign last_write = write_end && (frame_cnt == CNT_W'(N_FRAMES - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        first      = 1'b0;
        launch     = 1'b0;
        short_err  = 1'b0;
        over_err   = 1'b0;
        case (state)
            IDLE: begin
                if (!sen) begin
                    shift_en   = 1'b1;
                    first      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (sen) begin
                    short_err  = 1'b1;
                    next_state = IDLE;
                end else begin
                    shift_en = 1'b1;
                    if (frame_full) begin
                        launch     = 1'b1;
                        next_state = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!sen && !over_seen) begin
                    over_err = 1'b1;
                end
                // Completion wins over returning to IDLE on the write cycle.
                if (last_write) begin
                    next_state = DONE;
                end else if (sen) begin
                    next_state = IDLE;
                end
            end
            DONE: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Write port, completion, error pulse and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_wen   <= 1'b1;
            mem_a     <= '0;
            mem_d     <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            frame_cnt <= '0;
            over_seen <= 1'b0;
        end else begin
            mem_wen   <= ~launch;
            frame_err <= short_err;
            if (launch) begin
                mem_a     <= word[FRAME_BITS-1 -: ADDR_W];
                mem_d     <= word[DATA_W-1:0];
                over_seen <= 1'b0;
            end
            if (over_err) begin
                over_seen <= 1'b1;
            end
            if (short_err || over_err) begin
                err_cnt <= sat_inc4(err_cnt);
            end
            if (write_end) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
            if (last_write) begin
                done <= 1'b1;
            end
        end
    end

endmodule
